timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_pkg.sv | 23 ++
 rtl/timer_counter.sv | 93 +++++++++
 tb/tb_timer_counter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared constants for the bus-mapped timer: register offsets, FSM states,
// counting modes and CTRL bit positions.
package timer_counter_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ONESHOT    = 2'b00;
    localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM       = 3;

endpackage

// File: rtl/timer_counter.sv
// Down-counting timer with one-shot / auto-reload modes, a maskable
// interrupt and a three-register bus interface.
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr;

    assign sel         = Addr[3:2];
    assign wr_ctrl     = We && (sel == ADDR_CTRL);
    assign wr_preset   = We && (sel == ADDR_PRESET);
    assign unused_addr = ^Addr[31:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl[CTRL_EN])
                        state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (ctrl[CTRL_MODE_LSB +: 2] == MODE_ONESHOT)
                        ctrl[CTRL_EN] <= 1'b0;
                    else
                        irq_flag <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Bus writes come last so they override any same-edge FSM update.
            if (wr_ctrl) begin
                ctrl     <= Din[3:0];
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset   <= Din;
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (sel)
            ADDR_CTRL:   Dout = {28'b0, ctrl};
            ADDR_PRESET: Dout = preset;
            ADDR_COUNT:  Dout = count;
            default:     Dout = '0;
        endcase
    end

    assign IRQ = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: expectations are queued per cycle and
// compared against the register read-back and IRQ pin.
`timescale 1ns/1ps
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:2] Addr = '0;
    logic        We = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;

    typedef struct {
        string       tag;
        bit          is_irq;
        logic [1:0]  a;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [1:0] ADDR_RSVD = 2'b11;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .We    (We),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_addr(input logic [1:0] a);
        // Instance sits at byte base 0x7F00, i.e. word address 0x1FC0.
        Addr = 30'h1FC0 | 30'(a);
    endtask

    task automatic exp_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
        sb.push_back('{tag: tag, is_irq: 1'b0, a: a, v: v});
    endtask

    task automatic exp_irq(input string tag, input logic v);
        sb.push_back('{tag: tag, is_irq: 1'b1, a: 2'b00, v: {31'b0, v}});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_irq) begin
                #0.2;
                check(e.tag, {31'b0, IRQ}, e.v);
            end else begin
                set_addr(e.a);
                #0.2;
                check(e.tag, Dout, e.v);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write(input logic [1:0] a, input logic [31:0] d);
        set_addr(a);
        Din = d;
        We  = 1'b1;
        @(negedge clk);
        We  = 1'b0;
    endtask

    task automatic do_reset();
        We    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] cnt_exp;
        logic        irq_exp;

        // Reset state
        do_reset();
        exp_reg("rst_ctrl",   ADDR_CTRL,   32'h0);
        exp_reg("rst_preset", ADDR_PRESET, 32'h0);
        exp_reg("rst_count",  ADDR_COUNT,  32'h0);
        exp_reg("rst_rsvd",   ADDR_RSVD,   32'h0);
        exp_irq("rst_irq", 1'b0);
        drain();

        // One-shot, PRESET=3, CTRL=0x9 at edge k
        write(ADDR_PRESET, 32'd3);
        write(ADDR_CTRL, 32'h9);
        tick();
        exp_reg("os_load_count", ADDR_COUNT, 32'd0);
        drain();
        for (int j = 2; j <= 5; j++) begin
            tick();
            cnt_exp = (j == 5) ? 32'd0 : 32'(5 - j);
            exp_reg($sformatf("os_count_k%0d", j), ADDR_COUNT, cnt_exp);
            exp_irq($sformatf("os_irq_k%0d", j), j == 5);
            drain();
        end
        tick();
        exp_reg("os_ctrl_k6", ADDR_CTRL, 32'h8);
        exp_irq("os_irq_k6", 1'b1);
        drain();
        tick();
        exp_irq("os_irq_held", 1'b1);
        exp_reg("os_count_idle", ADDR_COUNT, 32'd0);
        drain();
        write(ADDR_CTRL, 32'h8);
        exp_irq("os_irq_clear", 1'b0);
        exp_reg("os_ctrl_after", ADDR_CTRL, 32'h8);
        drain();

        // Masked one-shot, PRESET=1, CTRL=0x1
        do_reset();
        write(ADDR_PRESET, 32'd1);
        write(ADDR_CTRL, 32'h1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            exp_irq($sformatf("mask_irq_k%0d", j), 1'b0);
            drain();
        end
        exp_reg("mask_ctrl_off", ADDR_CTRL, 32'h0);
        drain();
        write(ADDR_CTRL, 32'h8);
        exp_irq("mask_irq_unmask", 1'b0);
        drain();

        // Simultaneous CTRL write on the one-shot INT edge
        do_reset();
        write(ADDR_PRESET, 32'd1);
        write(ADDR_CTRL, 32'h9);
        tick(); tick(); tick();
        exp_irq("sim_irq_k3", 1'b1);
        drain();
        write(ADDR_CTRL, 32'h9);
        exp_reg("sim_ctrl", ADDR_CTRL, 32'h9);
        exp_irq("sim_irq_cleared", 1'b0);
        drain();
        tick();
        tick();
        exp_reg("sim_reload", ADDR_COUNT, 32'd1);
        drain();
        tick();
        exp_irq("sim_irq_again", 1'b1);
        drain();

        // Auto-reload, PRESET=2, CTRL=0xB: period 5
        do_reset();
        write(ADDR_PRESET, 32'd2);
        write(ADDR_CTRL, 32'hB);
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (j < 2) begin
                cnt_exp = 32'd0;
                irq_exp = 1'b0;
            end else begin
                case ((j - 2) % 5)
                    0:       cnt_exp = 32'd2;
                    1:       cnt_exp = 32'd1;
                    default: cnt_exp = 32'd0;
                endcase
                irq_exp = ((j - 2) % 5) == 2;
            end
            exp_reg($sformatf("ar_count_k%0d", j), ADDR_COUNT, cnt_exp);
            exp_irq($sformatf("ar_irq_k%0d", j), irq_exp);
            drain();
        end

        // PRESET=0 with Enable
        do_reset();
        write(ADDR_CTRL, 32'h9);
        tick(); tick();
        exp_reg("zero_count", ADDR_COUNT, 32'd0);
        exp_irq("zero_irq_cnt", 1'b0);
        drain();
        tick();
        exp_irq("zero_irq_int", 1'b1);
        drain();
        tick();
        exp_reg("zero_ctrl", ADDR_CTRL, 32'h8);
        drain();

        // Bus access and mid-count reset, PRESET=10
        do_reset();
        write(ADDR_PRESET, 32'd10);
        write(ADDR_CTRL, 32'h1);
        tick(); tick();
        exp_reg("bus_count_k2", ADDR_COUNT, 32'd10);
        drain();
        tick();
        exp_reg("bus_count_k3", ADDR_COUNT, 32'd9);
        drain();
        write(ADDR_COUNT, 32'h1234);
        exp_reg("bus_count_ro", ADDR_COUNT, 32'd8);
        drain();
        write(ADDR_PRESET, 32'h55);
        exp_reg("bus_preset_mid", ADDR_COUNT, 32'd7);
        exp_reg("bus_preset_val", ADDR_PRESET, 32'h55);
        drain();
        write(ADDR_RSVD, 32'hFFFF);
        exp_reg("bus_rsvd_read", ADDR_RSVD, 32'd0);
        exp_reg("bus_count_k6", ADDR_COUNT, 32'd6);
        drain();
        tick();
        exp_reg("bus_count_5", ADDR_COUNT, 32'd5);
        drain();
        #2;
        reset = 1'b1;
        #1;
        exp_reg("arst_ctrl",   ADDR_CTRL,   32'h0);
        exp_reg("arst_preset", ADDR_PRESET, 32'h0);
        exp_reg("arst_count",  ADDR_COUNT,  32'h0);
        exp_irq("arst_irq", 1'b0);
        drain();
        tick();
        reset = 1'b0;
        write(ADDR_PRESET, 32'd4);
        tick(); tick(); tick();
        exp_reg("post_rst_idle_count", ADDR_COUNT, 32'd0);
        exp_reg("post_rst_ctrl", ADDR_CTRL, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
